// File: rtl/vector_fetch.sv
// Fetches a two-byte vector (low byte at vec, high byte at vec+1) over a req/ack read
// port and writes it to the PC register; reset, NMI and IRQ requests are held until served.
module vector_fetch #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8,
  parameter logic [ADDR_WIDTH-1:0] NMI_VECTOR   = 16'hFFFA,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = 16'hFFFC,
  parameter logic [ADDR_WIDTH-1:0] IRQ_VECTOR   = 16'hFFFE
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_nmi,
  input  logic                  start_irq,
  output logic                  busy,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  pc_we,
  output logic [ADDR_WIDTH-1:0] pc_din,
  output logic                  done
);

  typedef enum logic [1:0] {IDLE, REQ_LO, REQ_HI, LOAD} state_t;

  localparam logic [ADDR_WIDTH-1:0] ONE = 1;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] vec_q, vec_d;
  logic [DATA_WIDTH-1:0] lo_q, lo_d, hi_q, hi_d;
  logic                  pend_rst_q, pend_rst_d;
  logic                  pend_nmi_q, pend_nmi_d;
  logic                  pend_irq_q, pend_irq_d;

  always_comb begin
    state_d    = state_q;
    vec_d      = vec_q;
    lo_d       = lo_q;
    hi_d       = hi_q;
    pend_rst_d = pend_rst_q;
    pend_nmi_d = pend_nmi_q | start_nmi;
    pend_irq_d = pend_irq_q | start_irq;
    case (state_q)
      IDLE: begin
        // A held request is cleared when served, unless a fresh pulse lands on the same edge.
        if (pend_rst_q) begin
          vec_d      = RESET_VECTOR;
          pend_rst_d = 1'b0;
          state_d    = REQ_LO;
        end else if (pend_nmi_q | start_nmi) begin
          vec_d      = NMI_VECTOR;
          pend_nmi_d = pend_nmi_q & start_nmi;
          state_d    = REQ_LO;
        end else if (pend_irq_q | start_irq) begin
          vec_d      = IRQ_VECTOR;
          pend_irq_d = pend_irq_q & start_irq;
          state_d    = REQ_LO;
        end
      end
      REQ_LO: begin
        if (mem_ack) begin
          lo_d    = mem_rdata;
          state_d = REQ_HI;
        end
      end
      REQ_HI: begin
        if (mem_ack) begin
          hi_d    = mem_rdata;
          state_d = LOAD;
        end
      end
      LOAD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      vec_q      <= '0;
      lo_q       <= '0;
      hi_q       <= '0;
      pend_rst_q <= 1'b1;
      pend_nmi_q <= 1'b0;
      pend_irq_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      vec_q      <= vec_d;
      lo_q       <= lo_d;
      hi_q       <= hi_d;
      pend_rst_q <= pend_rst_d;
      pend_nmi_q <= pend_nmi_d;
      pend_irq_q <= pend_irq_d;
    end
  end

  // Outputs decode straight from state so an asynchronous reset clears them immediately.
  always_comb begin
    busy     = (state_q != IDLE);
    mem_req  = (state_q == REQ_LO) || (state_q == REQ_HI);
    mem_addr = '0;
    if (state_q == REQ_LO) mem_addr = vec_q;
    if (state_q == REQ_HI) mem_addr = vec_q + ONE;
    pc_we    = (state_q == LOAD);
    done     = pc_we;
    pc_din   = pc_we ? {hi_q, lo_q} : '0;
  end

endmodule

// File: tb/tb_vector_fetch.sv
// Random request/wait-state stimulus on two instances (standard vectors, and IRQ vector at 16'hFFFF)
// checked against a fetch-timeline model: each fetch spans (w0+1)+(w1+1)+1 cycles.
`timescale 1ns/1ps
module tb_vector_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_nmi, start_irq, mem_ack;
  logic [7:0]  rdata_a, rdata_b;
  logic        busy_a, req_a, we_a, done_a;
  logic        busy_b, req_b, we_b, done_b;
  logic [15:0] addr_a, din_a, addr_b, din_b;

  always #5 clk = ~clk;

  vector_fetch u_dut_a (
    .clk(clk), .reset(reset), .start_nmi(start_nmi), .start_irq(start_irq),
    .busy(busy_a), .mem_req(req_a), .mem_addr(addr_a), .mem_ack(mem_ack),
    .mem_rdata(rdata_a), .pc_we(we_a), .pc_din(din_a), .done(done_a)
  );

  vector_fetch #(.IRQ_VECTOR(16'hFFFF)) u_dut_b (
    .clk(clk), .reset(reset), .start_nmi(start_nmi), .start_irq(start_irq),
    .busy(busy_b), .mem_req(req_b), .mem_addr(addr_b), .mem_ack(mem_ack),
    .mem_rdata(rdata_b), .pc_we(we_b), .pc_din(din_b), .done(done_b)
  );

  logic [7:0] mem [0:65535];

  int n_cmp = 0;
  int n_bad = 0;

  // reference model: pending requests plus position within the current fetch
  logic pend_rst, pend_nmi, pend_irq;
  logic active, first;
  int   t, w0, w1, sel, len_lo, len_hi, n_done;
  logic [15:0] vec_a, vec_b;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_outs(input string inst, input logic [15:0] vec,
                          input logic busy, input logic req, input logic [15:0] addr,
                          input logic we, input logic [15:0] din, input logic dn);
    logic [15:0] vec1, e_addr, e_din;
    logic        e_busy, e_req, e_we;
    vec1   = vec + 16'd1;
    e_busy = active;
    e_req  = active && (t < len_lo + len_hi);
    e_addr = !active ? 16'h0 : (t < len_lo) ? vec : (t < len_lo + len_hi) ? vec1 : 16'h0;
    e_we   = active && (t == len_lo + len_hi);
    e_din  = e_we ? {mem[vec1], mem[vec]} : 16'h0;
    chk({inst, "_busy"}, 32'(busy), 32'(e_busy));
    chk({inst, "_req"},  32'(req),  32'(e_req));
    chk({inst, "_addr"}, 32'(addr), 32'(e_addr));
    chk({inst, "_we"},   32'(we),   32'(e_we));
    chk({inst, "_din"},  32'(din),  32'(e_din));
    chk({inst, "_done"}, 32'(dn),   32'(e_we));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_a"}, {busy_a, req_a, we_a, done_a, addr_a, din_a} == 0 ? 32'd0 : 32'd1, 32'd0);
    chk({tag, "_b"}, {busy_b, req_b, we_b, done_b, addr_b, din_b} == 0 ? 32'd0 : 32'd1, 32'd0);
  endtask

  task automatic begin_fetch(input int s);
    sel    = s;
    vec_a  = (s == 0) ? 16'hFFFC : (s == 1) ? 16'hFFFA : 16'hFFFE;
    vec_b  = (s == 2) ? 16'hFFFF : vec_a;
    w0     = first ? 0 : int'($urandom_range(3));
    w1     = first ? 0 : int'($urandom_range(3));
    first  = 1'b0;
    active = 1'b1;
    t      = 0;
  endtask

  initial begin
    logic sn, si;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    mem[16'hFFFC] = 8'h34;
    mem[16'hFFFD] = 8'h12;
    reset = 1'b1; start_nmi = 1'b0; start_irq = 1'b0; mem_ack = 1'b0;
    rdata_a = 8'h0; rdata_b = 8'h0;
    pend_rst = 1'b1; pend_nmi = 1'b0; pend_irq = 1'b0;
    active = 1'b0; first = 1'b1; t = 0; w0 = 0; w1 = 0; sel = 0; n_done = 0;
    vec_a = 16'h0; vec_b = 16'h0;
    repeat (2) @(posedge clk);
    #1 chk_zero("reset_outs");
    @(negedge clk);
    reset = 1'b0;

    for (int cyc = 0; cyc < 3000; cyc++) begin
      len_lo = w0 + 1;
      len_hi = w1 + 1;
      if (cyc > 20 && active && t >= len_lo && t < len_lo + len_hi && $urandom_range(5) == 0) begin
        reset = 1'b1; start_nmi = 1'b0; start_irq = 1'b0; mem_ack = 1'b0;
        #1 chk_zero("abort_outs");
        @(negedge clk);
        reset = 1'b0;
        active = 1'b0; pend_rst = 1'b1; pend_nmi = 1'b0; pend_irq = 1'b0;
        continue;
      end

      sn = ($urandom_range(11) == 0);
      si = ($urandom_range(11) == 0);
      start_nmi = sn;
      start_irq = si;
      if (active && (t == w0 || t == len_lo + w1)) begin
        mem_ack = 1'b1;
        rdata_a = (t == w0) ? mem[vec_a] : mem[16'(vec_a + 16'd1)];
        rdata_b = (t == w0) ? mem[vec_b] : mem[16'(vec_b + 16'd1)];
      end else begin
        mem_ack = (active && t < len_lo + len_hi) ? 1'b0 : ($urandom_range(3) == 0);
        rdata_a = 8'($urandom);
        rdata_b = 8'($urandom);
      end

      chk_outs("a", vec_a, busy_a, req_a, addr_a, we_a, din_a, done_a);
      chk_outs("b", vec_b, busy_b, req_b, addr_b, we_b, din_b, done_b);

      if (!active) begin
        if (pend_rst) begin
          pend_rst = 1'b0; pend_nmi = pend_nmi | sn; pend_irq = pend_irq | si;
          begin_fetch(0);
        end else if (pend_nmi || sn) begin
          pend_nmi = pend_nmi & sn; pend_irq = pend_irq | si;
          begin_fetch(1);
        end else if (pend_irq || si) begin
          pend_irq = pend_irq & si;
          begin_fetch(2);
        end
      end else begin
        pend_nmi = pend_nmi | sn;
        pend_irq = pend_irq | si;
        if (t == len_lo + len_hi) begin
          active = 1'b0;
          n_done++;
        end else begin
          t++;
        end
      end
      @(negedge clk);
    end

    start_nmi = 1'b0; start_irq = 1'b0; mem_ack = 1'b0;
    chk("fetches_completed", (n_done > 50) ? 32'd1 : 32'd0, 32'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
